exe_iter_div: RTL and testbench
===============================

Name: exe_iter_div

Overview:
- Self-contained radix-2 iterative integer divider for the execute stage; replaces the vendor divider IP on the div/mod path.
- Computes quotient and remainder together, signed or unsigned, with width set by parameter.
- Valid/ready on both sides so the stage can stall on it. Synchronous flush discards in-flight work on exception or ertn.
- Carries a tag (destination register) alongside the operation.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
TAG_W, 5, width of pass-through tag

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  cancel any accepted/in-flight operation
in_valid  in  1  operation request
in_ready  out  1  unit can accept (state IDLE)
in_signed  in  1  1 = two's-complement operands
in_dividend  in  WIDTH  dividend
in_divisor  in  WIDTH  divisor
in_tag  in  TAG_W  opaque tag, returned with result
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_quotient  out  WIDTH  quotient
out_remainder  out  WIDTH  remainder
out_tag  out  TAG_W  tag of this result
out_div_by_zero  out  1  divisor was zero
busy  out  1  state != IDLE

Behaviour:
- Reset and clock: reset is synchronous and active-high; the clock is clk. Reset puts the unit in IDLE and clears every output register (out_valid, out_quotient, out_remainder, out_tag, out_div_by_zero) to 0. in_ready = 1 and busy = 0 in the cycle after reset is released.
- States: IDLE, CALC, DONE. in_ready = (state == IDLE); busy = !in_ready.
- Accept: capture on in_valid && in_ready && !flush at the clock edge, then go to CALC. The captured values are:
  - abs(dividend) and abs(divisor), each taken only if in_signed and the MSB is set;
  - q_neg = in_signed & (dividend MSB ^ divisor MSB);
  - r_neg = in_signed & dividend MSB;
  - in_tag;
  - div_by_zero = (divisor == 0);
  - iteration counter = WIDTH (width clog2(WIDTH+1)).
- CALC (restoring algorithm): each cycle, shift {rem, quo} left by 1 to form a (WIDTH+1)-bit trial value. If trial >= |divisor|, subtract the divisor and set the quotient LSB to 1. Decrement the counter.
- Finishing CALC: on the edge where the counter goes 1 -> 0:
  - apply the sign fix (quotient = -q if q_neg; remainder = -r if r_neg, modulo 2^WIDTH);
  - load the output registers;
  - go to DONE.
- Latency: accept in cycle T; CALC occupies cycles T+1..T+WIDTH; out_valid = 1 from cycle T+WIDTH+1.
- DONE:
  - Outputs are held stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE. out_valid drops in the next cycle and in_ready rises in the next cycle.
  - No same-cycle re-accept from DONE.
- Flush:
  - In any state, flush forces IDLE on the next edge and out_valid = 0 from the next cycle. No result is delivered.
  - In the same cycle, flush beats accept (no capture) and beats out handshake (the result is dropped).
- Signed overflow: MIN / -1 gives quotient = MIN and remainder = 0. This falls out of the algorithm naturally and is not trapped.
- Division by zero without the fast path: results follow from the algorithm.
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed, dividend >= 0: quotient = all ones (-1), remainder = dividend.
  - Signed, dividend < 0: quotient = 1, remainder = dividend.
  - out_div_by_zero = 1 in all of these cases.
- Reset mid-operation: the operation is abandoned and the unit ends in the reset state.
- The unit never drives in_ready while out_valid = 1.

Optional Feature:
Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - When divisor == 0 at accept, skip CALC and load the outputs on the accept edge: quotient = all ones, remainder = raw dividend, out_div_by_zero = 1.
  - This holds for signed and unsigned alike.
  - out_valid is asserted in cycle T+1.
- Undefined: divide-by-zero takes the full WIDTH iterations and yields the algorithmic results given in Behaviour.
- All non-zero-divisor behaviour is identical with and without the macro.

Test Plan:
1. WIDTH=32, unsigned 100/7, tag 5, accept in cycle T -> out_valid first high in cycle T+33; quotient 14, remainder 2, out_tag 5, out_div_by_zero 0.
2. Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1. Unsigned 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
3. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
4. Unsigned 0x1234/0 -> quotient 0xFFFFFFFF, remainder 0x1234, out_div_by_zero 1; latency 33 cycles without DIV_ZERO_BYPASS_EN, 1 cycle with it. Signed 0xFFFFFFF0/0 without the macro -> quotient 1, remainder 0xFFFFFFF0.
5. Accept 1000/3, then flush in the 10th CALC cycle -> out_valid never rises for it, in_ready = 1 next cycle. Then 9/3 -> quotient 3, remainder 0, tag correct. Also check flush asserted together with in_valid in IDLE -> nothing captured.
6. Hold out_ready low for 5 cycles in DONE -> outputs and out_valid stable, in_ready 0. Raise out_ready -> next cycle IDLE, out_valid 0, in_ready 1. Back-to-back ops with out_ready tied high -> one result every 34 cycles.

Source files
------------

// File: rtl/exe_iter_div.sv
// exe_iter_div: radix-2 restoring integer divider for the execute stage.
// Computes quotient and remainder together, signed or unsigned, WIDTH bits.
// Ports:
//   clk, reset (synchronous, active-high), flush (drop in-flight work)
//   in_valid/in_ready, in_signed, in_dividend, in_divisor, in_tag
//   out_valid/out_ready, out_quotient, out_remainder, out_tag,
//   out_div_by_zero, busy (unit not idle)
// Optional build macro DIV_ZERO_BYPASS_EN: a zero divisor is answered on
// the accept edge (quotient all ones, remainder = raw dividend).
module exe_iter_div #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_div_by_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dbz_q, dbz_d;

   logic             ov_q, ov_d;
   logic [WIDTH-1:0] oq_q, oq_d;
   logic [WIDTH-1:0] or_q, or_d;
   logic [TAG_W-1:0] ot_q, ot_d;
   logic             oz_q, oz_d;

   // operand magnitudes
   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;

   assign dvd_neg = in_signed & in_dividend[WIDTH-1];
   assign dvs_neg = in_signed & in_divisor[WIDTH-1];
   assign dvd_abs = dvd_neg ? -in_dividend : in_dividend;
   assign dvs_abs = dvs_neg ? -in_divisor : in_divisor;

   // one restoring step: {rem, quo} shifts left, the dividend
   // bits stream out of quo's MSB into rem while quotient bits
   // fill quo from the LSB
   logic [WIDTH:0]   trial;
   logic             take;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign trial  = {rem_q, quo_q[WIDTH-1]};
   assign take   = trial >= {1'b0, dvs_q};
   // when take is set the difference fits in WIDTH bits
   assign rem_nx = take ? (trial[WIDTH-1:0] - dvs_q)
                        : trial[WIDTH-1:0];
   assign quo_nx = {quo_q[WIDTH-2:0], take};
   assign q_fix  = q_neg_q ? -quo_nx : quo_nx;
   assign r_fix  = r_neg_q ? -rem_nx : rem_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         tag_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dbz_q   <= 1'b0;
         ov_q    <= 1'b0;
         oq_q    <= '0;
         or_q    <= '0;
         ot_q    <= '0;
         oz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dbz_q   <= dbz_d;
         ov_q    <= ov_d;
         oq_q    <= oq_d;
         or_q    <= or_d;
         ot_q    <= ot_d;
         oz_q    <= oz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dbz_d   = dbz_q;
      ov_d    = ov_q;
      oq_d    = oq_q;
      or_d    = or_q;
      ot_d    = ot_q;
      oz_d    = oz_q;

      if (flush) begin
         // flush wins over accept and over the result handshake
         state_d = IDLE;
         ov_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_d = CALC;
                  rem_d   = '0;
                  quo_d   = dvd_abs;
                  dvs_d   = dvs_abs;
                  cnt_d   = CW'(WIDTH);
                  tag_d   = in_tag;
                  q_neg_d = in_signed &
                            (in_dividend[WIDTH-1] ^
                             in_divisor[WIDTH-1]);
                  r_neg_d = dvd_neg;
                  dbz_d   = (in_divisor == '0);
`ifdef DIV_ZERO_BYPASS_EN
                  if (in_divisor == '0) begin
                     state_d = DONE;
                     ov_d    = 1'b1;
                     oq_d    = '1;
                     or_d    = in_dividend;
                     ot_d    = in_tag;
                     oz_d    = 1'b1;
                  end
`endif
               end
            end
            CALC: begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
                  ov_d    = 1'b1;
                  oq_d    = q_fix;
                  or_d    = r_fix;
                  ot_d    = tag_q;
                  oz_d    = dbz_q;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  ov_d    = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               ov_d    = 1'b0;
            end
         endcase
      end
   end

   assign in_ready        = (state_q == IDLE);
   assign busy            = ~in_ready;
   assign out_valid       = ov_q;
   assign out_quotient    = oq_q;
   assign out_remainder   = or_q;
   assign out_tag         = ot_q;
   assign out_div_by_zero = oz_q;

endmodule

// File: tb/tb_exe_iter_div.sv
// tb_exe_iter_div: directed and randomized checks of exe_iter_div
// against a transaction-level arithmetic model.
module tb_exe_iter_div;

   localparam int W   = 32;
   localparam int TW  = 5;
   localparam int LAT = W + 1;
`ifdef DIV_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W + 1;
`endif

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } res_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_signed = 1'b0;
   logic [W-1:0]  in_dividend = '0;
   logic [W-1:0]  in_divisor = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_quotient;
   logic [W-1:0]  out_remainder;
   logic [TW-1:0] out_tag;
   logic          out_div_by_zero;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic rnd_or = 1'b0;

   exe_iter_div #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_signed(in_signed),
      .in_dividend(in_dividend),
      .in_divisor(in_divisor),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_quotient(out_quotient),
      .out_remainder(out_remainder),
      .out_tag(out_tag),
      .out_div_by_zero(out_div_by_zero),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic chkb(input string nm, input logic act,
                       input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Arithmetic reference: truncating division, remainder takes
   // the dividend's sign, zero divisor follows the documented rules.
   function automatic res_t model(input logic s,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      res_t   m;
      longint sa, sb, tq, tr;
      m.z = (b == '0);
      if (b == '0) begin
`ifdef DIV_ZERO_BYPASS_EN
         m.q = '1;
`else
         m.q = (s && a[W-1]) ? W'(1) : '1;
`endif
         m.r = a;
      end else if (!s) begin
         m.q = a / b;
         m.r = a % b;
      end else begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         tq  = sa / sb;
         tr  = sa % sb;
         m.q = tq[W-1:0];
         m.r = tr[W-1:0];
      end
      return m;
   endfunction

   // Transaction-level monitor: at most one op outstanding; its
   // result must appear a fixed latency after accept and stay
   // until taken or flushed.
   logic          pend = 1'b0;
   int            due = 0;
   res_t          pres;
   logic [TW-1:0] ptag;
   logic          ev;

   always @(negedge clk) begin
      if (reset) begin
         pend = 1'b0;
      end else begin
         ev = pend && (cyc >= due);
         chkb("mon_out_valid", out_valid, ev);
         chkb("mon_in_ready", in_ready, !pend);
         chkb("mon_busy", busy, pend);
         if (ev) begin
            chk("mon_quotient", out_quotient, pres.q);
            chk("mon_remainder", out_remainder, pres.r);
            chk("mon_tag", 32'(out_tag), 32'(ptag));
            chkb("mon_dbz", out_div_by_zero, pres.z);
         end
         if (flush) begin
            pend = 1'b0;
         end else if (!pend && in_valid) begin
            pres = model(in_signed, in_dividend, in_divisor);
            ptag = in_tag;
            due  = cyc + ((in_divisor == '0) ? ZLAT : LAT);
            pend = 1'b1;
         end else if (ev && out_ready) begin
            pend = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rnd_or) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic issue(input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [TW-1:0] t, output int tacc);
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: in_ready=%b after %0d cycles",
                  in_ready, n);
      end
      in_valid    = 1'b1;
      in_signed   = s;
      in_dividend = a;
      in_divisor  = b;
      in_tag      = t;
      tacc        = cyc;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_signed   = 1'($urandom_range(0, 1));
      in_dividend = $urandom;
      in_divisor  = $urandom;
      in_tag      = TW'($urandom);
   endtask

   task automatic wait_valid(output int tv);
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) begin
         checks++;
         failures++;
         $display("FAIL wait_valid_timeout: out_valid=%b", out_valid);
      end
      tv = cyc;
   endtask

   task automatic dir(input string nm, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t,
                      input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic ez, input int elat);
      int ta, tv;
      out_ready = 1'b1;
      issue(s, a, b, t, ta);
      wait_valid(tv);
      chk({nm, "_latency"}, 32'(tv - ta), 32'(elat));
      chk({nm, "_q"}, out_quotient, eq);
      chk({nm, "_r"}, out_remainder, er);
      chk({nm, "_tag"}, 32'(out_tag), 32'(t));
      chkb({nm, "_dbz"}, out_div_by_zero, ez);
      @(posedge clk);
      #1;
      chkb({nm, "_in_ready_after"}, in_ready, 1'b1);
      chkb({nm, "_out_valid_after"}, out_valid, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int   ta, tv, prev, sel;
      logic seen;
      logic s;
      logic [W-1:0] a, b, hq, hr;
      res_t m;

      // model pinned by hand-computed values
      m = model(1'b1, 32'hFFFFFFF9, 32'd2);
      chk("model_sm7d2_q", m.q, 32'hFFFFFFFD);
      chk("model_sm7d2_r", m.r, 32'hFFFFFFFF);
      m = model(1'b1, 32'h80000000, 32'hFFFFFFFF);
      chk("model_min_q", m.q, 32'h80000000);
      m = model(1'b0, 32'd100, 32'd7);
      chk("model_u100d7_r", m.r, 32'd2);

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chkb("rst_in_ready", in_ready, 1'b1);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chk("rst_quotient", out_quotient, '0);
      chk("rst_remainder", out_remainder, '0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chkb("rst_dbz", out_div_by_zero, 1'b0);

      dir("u100d7", 1'b0, 32'd100, 32'd7, 5'd5,
          32'd14, 32'd2, 1'b0, LAT);
      dir("s_m7d2", 1'b1, 32'hFFFFFFF9, 32'd2, 5'd1,
          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT);
      dir("s_7dm2", 1'b1, 32'd7, 32'hFFFFFFFE, 5'd2,
          32'hFFFFFFFD, 32'd1, 1'b0, LAT);
      dir("u_f9d2", 1'b0, 32'hFFFFFFF9, 32'd2, 5'd3,
          32'h7FFFFFFC, 32'd1, 1'b0, LAT);
      dir("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd4,
          32'h80000000, 32'd0, 1'b0, LAT);
      dir("u_dz", 1'b0, 32'h1234, 32'd0, 5'd6,
          32'hFFFFFFFF, 32'h1234, 1'b1, ZLAT);
`ifdef DIV_ZERO_BYPASS_EN
      dir("s_neg_dz", 1'b1, 32'hFFFFFFF0, 32'd0, 5'd7,
          32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, ZLAT);
`else
      dir("s_neg_dz", 1'b1, 32'hFFFFFFF0, 32'd0, 5'd7,
          32'd1, 32'hFFFFFFF0, 1'b1, ZLAT);
`endif

      // flush in the 10th CALC cycle
      issue(1'b0, 32'd1000, 32'd3, 5'd9, ta);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chkb("flush_in_ready", in_ready, 1'b1);
      chkb("flush_out_valid", out_valid, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chkb("flush_no_result", seen, 1'b0);
      dir("after_flush", 1'b0, 32'd9, 32'd3, 5'd11,
          32'd3, 32'd0, 1'b0, LAT);

      // flush beats accept in IDLE
      in_valid    = 1'b1;
      flush       = 1'b1;
      in_dividend = 32'd77;
      in_divisor  = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      chkb("flush_accept_in_ready", in_ready, 1'b1);
      chkb("flush_accept_busy", busy, 1'b0);

      // result held while out_ready is low
      out_ready = 1'b0;
      issue(1'b0, 32'd50000, 32'd123, 5'd7, ta);
      wait_valid(tv);
      chk("hold_q", out_quotient, 32'd406);
      chk("hold_r", out_remainder, 32'd62);
      hq = out_quotient;
      hr = out_remainder;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("hold_q_stable", out_quotient, hq);
         chk("hold_r_stable", out_remainder, hr);
         chkb("hold_valid", out_valid, 1'b1);
         chkb("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chkb("release_valid", out_valid, 1'b0);
      chkb("release_in_ready", in_ready, 1'b1);

      // back-to-back with out_ready high: one op every LAT+1
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         b = $urandom;
         if (b == '0) b = 32'd3;
         issue(1'b1, $urandom, b, TW'(i), ta);
         if (i > 0) chk("b2b_spacing", 32'(ta - prev), 32'(LAT + 1));
         prev = ta;
      end
      wait_valid(tv);
      @(posedge clk);
      #1;

      // reset mid-operation
      issue(1'b0, 32'd12345, 32'd17, 5'd21, ta);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chkb("midrst_in_ready", in_ready, 1'b1);
      chkb("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_quotient", out_quotient, '0);
      chk("midrst_remainder", out_remainder, '0);
      chk("midrst_tag", 32'(out_tag), 32'd0);

      // randomized traffic, random backpressure, random flushes
      rnd_or = 1'b1;
      for (int i = 0; i < 150; i++) begin
         s   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 5);
         a   = $urandom;
         if (sel == 0) a = 32'h80000000;
         if (sel == 1) a = 32'($urandom_range(0, 40));
         if (sel == 2) a = 32'hFFFFFFFF;
         sel = $urandom_range(0, 9);
         b   = $urandom;
         if (sel == 0) b = '0;
         if (sel == 1) b = 32'hFFFFFFFF;
         if (sel >= 2 && sel <= 4) b = 32'($urandom_range(1, 15));
         if (sel == 5) b = -32'($urandom_range(1, 15));
         issue(s, a, b, TW'($urandom), ta);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 40)) begin
               @(posedge clk);
               #1;
            end
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
      end
      rnd_or    = 1'b0;
      out_ready = 1'b1;
      repeat (60) begin
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
